shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
- No parameters; data width fixed at 32 bits, shift amount at 5 bits.
- REQ-001: clock  input  1  single clock; all state SHALL update on its rising edge.
- REQ-002: reset  input  1  synchronous, active-high reset.
- REQ-003: req0_valid / req1_valid  input  1  requester N SHALL assert this when it presents an operation.
- REQ-004: req0_ready / req1_ready  output  1  the block SHALL assert this when it accepts requester N this cycle.
- REQ-005: req0_in / req1_in  input  32  operand.
- REQ-006: req0_op / req1_op  input  2  operation code: 00 = logical right, 01 = arithmetic right, 10 = logical left, 11 = illegal.
- REQ-007: req0_amt / req1_amt  input  5  shift amount, 0-31.
- REQ-008: rsp_valid  output  1  the block SHALL assert this while a result is held.
- REQ-009: rsp_ready  input  1  the consumer SHALL assert this to accept the result.
- REQ-010: rsp_id  output  1  index of the requester that owns the result.
- REQ-011: rsp_data  output  32  shifted result.
- REQ-012: rsp_err  output  1  set when the accepted op was 11.

Function
- REQ-013: The block SHALL contain exactly one Shifter instance, shared by both requesters; its operand, op and amount inputs come only from the internal operation registers.
- REQ-014: The FSM SHALL have three states: IDLE, EXEC and RESP.
- REQ-015: IDLE SHALL go to EXEC on acceptance; EXEC SHALL go to RESP unconditionally; RESP SHALL go to IDLE when rsp_ready=1, and otherwise stay in RESP.
- REQ-016: req0_ready and req1_ready SHALL be asserted only in IDLE, at most one at a time, and only toward a requester whose valid is high.
- REQ-017: Acceptance of requester N SHALL occur on the edge where reqN_valid && reqN_ready is true; in, op, amt and the requester id SHALL be latched on that edge.
- REQ-018: On the EXEC-to-RESP edge, the Shifter result SHALL be registered into rsp_data and rsp_valid set to 1.
- REQ-019: Latency SHALL be 2 cycles: rsp_valid is high on the second edge after the accept edge.
- REQ-020: rsp_data, rsp_id and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
- REQ-021: rsp_valid SHALL clear on the edge where rsp_valid && rsp_ready is true; the next acceptance SHALL be no earlier than the following cycle (peak throughput 1 op per 3 cycles).
- REQ-022: For op 11, rsp_data SHALL be 0x00000000 and rsp_err SHALL be 1; for all other ops, rsp_err SHALL be 0.
- REQ-023: For amount 0, rsp_data SHALL equal the operand for ops 00, 01 and 10.
- REQ-024: A requester SHALL keep valid and its fields stable until accepted; a valid dropped before acceptance is a protocol violation and the block SHALL not latch it.
- REQ-025: Arbitration SHALL occur only in IDLE; when exactly one valid is high, that requester SHALL be granted.

Reset
- REQ-026: On reset, the FSM SHALL enter IDLE; rsp_valid, rsp_err, rsp_id and both ready outputs SHALL be 0; rsp_data SHALL be 0x00000000; last_grant SHALL be 1.
- REQ-027: Reset asserted in EXEC or RESP SHALL discard the in-flight operation, and no response for it SHALL ever appear.
- REQ-028: Reset SHALL take priority over every simultaneous handshake.

Configuration
- REQ-029: With SHIFT_ARB_ROUND_ROBIN_EN defined, when both valids are high the block SHALL grant the requester not equal to last_grant, and last_grant SHALL update on every acceptance.
- REQ-030: Without SHIFT_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win contention (fixed priority), and last_grant SHALL be absent.

Verification
- REQ-031: req0 with in=0x80000000, op=01, amt=4 -> rsp_data=0xF8000000, rsp_id=0, rsp_err=0, rsp_valid high 2 cycles after accept.
- REQ-032: Same operand with op=00, amt=4 -> rsp_data=0x08000000; in=0x00000001, op=10, amt=31 -> rsp_data=0x80000000.
- REQ-033: Both requesters valid continuously, rsp_ready=1, round robin enabled -> rsp_id sequence 0,1,0,1; with the macro undefined -> 0,0,0,0.
- REQ-034: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable throughout and both ready outputs 0; one cycle after rsp_ready=1, the block is IDLE.
- REQ-035: op=11 with any in/amt -> rsp_data=0x00000000, rsp_err=1.
- REQ-036: Reset asserted in EXEC -> next cycle rsp_valid=0 and IDLE, with no stale response afterwards; an exhaustive sweep of in (from/quant/step plusargs) x amt 0-31 x ops 00/01/10 matches >>, >>> and <<.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Requester/consumer bundle for shift_arbiter: two shift requesters in, one response out.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_in;
  logic [1:0]  req0_op;
  logic [4:0]  req0_amt;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_in;
  logic [1:0]  req1_op;
  logic [4:0]  req1_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_in, req0_op, req0_amt,
    input  req1_valid, req1_in, req1_op, req1_amt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req0_in, req0_op, req0_amt,
    output req1_valid, req1_in, req1_op, req1_amt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter sharing one barrel shifter; IDLE -> EXEC -> RESP per operation.
// Optional macro SHIFT_ARB_ROUND_ROBIN_EN: round-robin on contention (default: requester 0 wins).
module shift_arbiter_shifter (
  input  logic [31:0] in_i,
  input  logic [1:0]  op_i,
  input  logic [4:0]  amt_i,
  output logic [31:0] data_o,
  output logic        err_o
);
  always_comb begin
    data_o = 32'h0;
    err_o  = 1'b0;
    case (op_i)
      2'b00:   data_o = in_i >> amt_i;
      2'b01:   data_o = $unsigned($signed(in_i) >>> amt_i);
      2'b10:   data_o = in_i << amt_i;
      default: err_o  = 1'b1;
    endcase
  end
endmodule

module shift_arbiter (
  input  logic          clock,
  input  logic          reset,
  shift_arbiter_if.slave bus,
  output logic [1:0]    dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] in_q, in_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  amt_q, amt_d;
  logic        id_q, id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        grant0, grant1;
  logic        ready0, ready1, accept;
  logic [31:0] sh_data;
  logic        sh_err;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = ready1;
  end

  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid && !bus.req0_valid;
  end
`endif

  // Readies are gated by reset so a handshake can never coincide with reset.
  assign ready0 = (state_q == S_IDLE) && !reset && grant0;
  assign ready1 = (state_q == S_IDLE) && !reset && grant1;
  assign accept = ready0 || ready1;

  shift_arbiter_shifter u_shifter (
    .in_i   (in_q),
    .op_i   (op_q),
    .amt_i  (amt_q),
    .data_o (sh_data),
    .err_o  (sh_err)
  );

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    op_d        = op_q;
    amt_d       = amt_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          in_d    = ready1 ? bus.req1_in  : bus.req0_in;
          op_d    = ready1 ? bus.req1_op  : bus.req0_op;
          amt_d   = ready1 ? bus.req1_amt : bus.req0_amt;
          id_d    = ready1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d  = sh_data;
        rsp_err_d   = sh_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_q        <= 32'h0;
      op_q        <= 2'b00;
      amt_q       <= 5'd0;
      id_q        <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      op_q        <= op_d;
      amt_q       <= amt_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_id     = rsp_id_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, corner sequences, randomized ops vs. arithmetic model.
module tb_shift_arbiter;
  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  logic [33:0] exp_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;

  shift_arbiter_if bus();

  shift_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [33:0] model(input logic id, input logic [31:0] din,
                                        input logic [1:0] op, input logic [4:0] amt);
    longint unsigned p;
    longint unsigned v;
    logic [31:0] r;
    logic        e;
    p = 64'd1;
    for (int k = 0; k < 32; k++) if (k < int'(amt)) p = p * 64'd2;
    v = {32'h0, din};
    e = 1'b0;
    case (op)
      2'b00: r = 32'(v / p);
      2'b01: r = din[31] ? ~32'(({32'h0, ~din}) / p) : 32'(v / p);
      2'b10: r = 32'(v * p);
      default: begin r = 32'h0; e = 1'b1; end
    endcase
    return {id, e, r};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_in = 32'h0; bus.req0_op = 2'b00; bus.req0_amt = 5'd0;
    bus.req1_valid = 1'b0; bus.req1_in = 32'h0; bus.req1_op = 2'b00; bus.req1_amt = 5'd0;
  endtask

  task automatic drive_req(input logic id, input logic [31:0] din,
                           input logic [1:0] op, input logic [4:0] amt);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_in = din; bus.req0_op = op; bus.req0_amt = amt;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_in = din; bus.req1_op = op; bus.req1_amt = amt;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One full transaction from the negedge: request, accept, latency, result, drain.
  task automatic do_op(input logic id, input logic [31:0] din,
                       input logic [1:0] op, input logic [4:0] amt);
    logic [33:0] exp;
    bit got;
    exp = exp_q.pop_front();
    bus.rsp_ready = 1'b0;
    drive_req(id, din, op, amt);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no ready expected ready for id %0d", id);
      clear_reqs();
      return;
    end
    @(posedge clock);
    @(negedge clock);
    clear_reqs();
    check("exec_state", 32'(dbg_state), 32'(ST_EXEC));
    check("exec_no_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clock);
    check("lat2_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_data", bus.rsp_data, exp[31:0]);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp[32]));
    check("rsp_id", 32'(bus.rsp_id), 32'(exp[33]));
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    check("rsp_clear", 32'(bus.rsp_valid), 32'd0);
    check("back_idle", 32'(dbg_state), 32'(ST_IDLE));
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        id;
    logic [31:0] din;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] hold_data;
    logic        ids[4];
    logic        exp_ids[4];
    int          nid;
    bit          stale;
    logic        rid;
    logic [31:0] rin;
    logic [1:0]  rop;
    logic [4:0]  ramt;

    checks = 0;
    errors = 0;
    vecs[0] = '{1'b0, 32'h8000_0000, 2'b01, 5'd4,  32'hF800_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h8000_0000, 2'b00, 5'd4,  32'h0800_0000, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0001, 2'b10, 5'd31, 32'h8000_0000, 1'b0};
    vecs[3] = '{1'b1, 32'hDEAD_BEEF, 2'b11, 5'd7,  32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 32'h1234_5678, 2'b11, 5'd0,  32'h0000_0000, 1'b1};
    vecs[5] = '{1'b0, 32'hCAFE_F00D, 2'b00, 5'd0,  32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1'b1, 32'hCAFE_F00D, 2'b01, 5'd0,  32'hCAFE_F00D, 1'b0};
    vecs[7] = '{1'b0, 32'hCAFE_F00D, 2'b10, 5'd0,  32'hCAFE_F00D, 1'b0};
    vecs[8] = '{1'b1, 32'h8000_0000, 2'b01, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[9] = '{1'b1, 32'h7FFF_FFFF, 2'b01, 5'd31, 32'h0000_0000, 1'b0};

    // Reset state, with both valids high so the ready gating is exercised.
    reset = 1'b1;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    clear_reqs();
    reset = 1'b0;
    @(negedge clock);

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({vecs[i].id, vecs[i].exp_err, vecs[i].exp_data});
      do_op(vecs[i].id, vecs[i].din, vecs[i].op, vecs[i].amt);
    end

    // Response stall: five cycles of backpressure with the other requester waiting.
    drive_req(1'b1, 32'hF0F0_0000, 2'b00, 5'd8);
    #1;
    check("stall_accept_rdy", 32'(bus.req1_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    clear_reqs();
    drive_req(1'b0, 32'h0000_00FF, 2'b10, 5'd4);
    @(negedge clock);
    hold_data = bus.rsp_data;
    check("stall_first_data", hold_data, 32'h00F0_F000);
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_data", bus.rsp_data, hold_data);
      check("stall_id", 32'(bus.rsp_id), 32'd1);
      check("stall_ready0", 32'(bus.req0_ready), 32'd0);
      check("stall_ready1", 32'(bus.req1_ready), 32'd0);
      @(negedge clock);
    end
    clear_reqs();
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    check("stall_release_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;

    // Reset while in EXEC discards the operation.
    drive_req(1'b0, 32'h0000_0001, 2'b10, 5'd3);
    @(posedge clock);
    @(negedge clock);
    clear_reqs();
    check("rexec_in_exec", 32'(dbg_state), 32'(ST_EXEC));
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rexec_valid", 32'(bus.rsp_valid), 32'd0);
    check("rexec_idle", 32'(dbg_state), 32'(ST_IDLE));
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.rsp_valid) stale = 1'b1;
    end
    check("rexec_no_stale", 32'(stale), 32'd0);
    bus.rsp_ready = 1'b0;

    // Contention with both valids held and the consumer always ready.
    do_reset();
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive_req(1'b0, 32'h0000_0010, 2'b00, 5'd1);
    drive_req(1'b1, 32'h0000_0010, 2'b10, 5'd1);
    bus.rsp_ready = 1'b1;
    nid = 0;
    for (int c = 0; c < 40 && nid < 4; c++) begin
      @(negedge clock);
      if (bus.rsp_valid) begin
        ids[nid] = bus.rsp_id;
        nid++;
      end
    end
    clear_reqs();
    check("contend_count", 32'(nid), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < nid) check($sformatf("contend_id%0d", k), 32'(ids[k]), 32'(exp_ids[k]));
    do_reset();

    // Amount sweep over all legal ops on a sign-set operand.
    for (int o = 0; o < 3; o++) begin
      for (int a = 0; a < 32; a++) begin
        rin = 32'hA5C3_9001;
        exp_q.push_back(model(1'b0, rin, 2'(o), 5'(a)));
        do_op(1'b0, rin, 2'(o), 5'(a));
      end
    end

    // Randomized ops against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      rid  = 1'($urandom_range(0, 1));
      rin  = $urandom;
      rop  = 2'($urandom_range(0, 3));
      ramt = 5'($urandom_range(0, 31));
      exp_q.push_back(model(rid, rin, rop, ramt));
      do_op(rid, rin, rop, ramt);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "time limit");
  end
endmodule
